// File: rtl/plaintext_packer_pkg.sv
// Shared constants and types for the plaintext byte-to-word packer.
package plaintext_packer_pkg;

  localparam int unsigned SYS_DWIDTH = 8;
  localparam int unsigned MST_DWIDTH = 32;
  localparam int unsigned LANES      = MST_DWIDTH / SYS_DWIDTH;

  typedef logic [LANES-1:0] byte_en_t;

  typedef struct packed {
    byte_en_t                byte_en;
    logic [MST_DWIDTH-1:0]   data;
  } fifo_entry_t;

endpackage

// File: rtl/plaintext_packer_fifo.sv
// First-word-fall-through synchronous FIFO; head is read straight from storage.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned PW       = $clog2(DEPTH);
  localparam logic [PW:0] LVL_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      level_q, level_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (level_q != '0);
    // a pop on the same edge frees the slot, so a push at full still lands
    do_push  = push && ((level_q != LVL_FULL) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (do_push && !do_pop) begin
      level_d = level_q + (PW+1)'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);

endmodule

// File: rtl/plaintext_packer.sv
// Packs a decrypted byte stream little-endian into 32-bit words behind a FWFT FIFO.
module plaintext_packer #(
  parameter int unsigned SYS_DWIDTH = 8,
  parameter int unsigned MST_DWIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_mst,
  input  logic                          rst,
  input  logic [SYS_DWIDTH-1:0]         data_i,
  input  logic                          valid_i,
  input  logic                          flush_i,
  output logic [MST_DWIDTH-1:0]         data_o,
  output logic [3:0]                    byte_en_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          full,
  output logic                          overflow
);

  import plaintext_packer_pkg::*;

  localparam int unsigned CNT_W = $clog2(LANES);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [MST_DWIDTH-1:0] asm_q, asm_d, asm_nxt;
  byte_en_t              mask_q, mask_d, mask_nxt;
  logic                  overflow_q, overflow_d;
  logic                  commit, pop;
  logic                  fifo_full, fifo_empty;
  fifo_entry_t           push_entry, head_entry;

  always_comb begin
    asm_nxt  = asm_q;
    mask_nxt = mask_q;
    if (valid_i) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (cnt_q == CNT_W'(k)) begin
          asm_nxt[k*SYS_DWIDTH +: SYS_DWIDTH] = data_i;
          mask_nxt[k]                         = 1'b1;
        end
      end
    end
    // the incoming byte is merged before the flush test, so valid+flush commits once
    commit = (valid_i && (cnt_q == CNT_W'(LANES-1))) || (flush_i && (mask_nxt != '0));
    push_entry.byte_en = mask_nxt;
    push_entry.data    = asm_nxt;
    pop = !fifo_empty && ready_i;

    if (commit) begin
      cnt_d  = '0;
      asm_d  = '0;
      mask_d = '0;
    end else begin
      cnt_d  = cnt_q + CNT_W'(valid_i);
      asm_d  = asm_nxt;
      mask_d = mask_nxt;
    end
    overflow_d = overflow_q || (commit && fifo_full && !pop);
  end

  always_ff @(posedge clk_mst) begin
    if (rst) begin
      cnt_q      <= '0;
      asm_q      <= '0;
      mask_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      mask_q     <= mask_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_mst),
    .rst   (rst),
    .push  (commit),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head_entry),
    .level (level_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign data_o    = head_entry.data;
  assign byte_en_o = head_entry.byte_en;
  assign valid_o   = !fifo_empty;
  assign full      = fifo_full;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_plaintext_packer.sv
// Randomised and directed bench for plaintext_packer against a queue-based model.
module tb_plaintext_packer;

  localparam int unsigned DEPTH = 4;

  logic        clk_mst = 1'b0;
  logic        rst     = 1'b1;
  logic [7:0]  data_i  = '0;
  logic        valid_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [31:0] data_o;
  logic [3:0]  byte_en_o;
  logic        valid_o;
  logic [2:0]  level_o;
  logic        full;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  plaintext_packer #(
    .SYS_DWIDTH (8),
    .MST_DWIDTH (32),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_mst   (clk_mst),
    .rst       (rst),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .flush_i   (flush_i),
    .data_o    (data_o),
    .byte_en_o (byte_en_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .level_o   (level_o),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk_mst = ~clk_mst;

  typedef struct {
    logic [3:0]  be;
    logic [31:0] data;
  } word_t;

  word_t      m_q[$];
  logic [7:0] m_pend[$];
  logic       m_ovf  = 1'b0;
  logic       chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Model: bytes accumulate in a list; a word forms at 4 bytes or on flush.
  always @(posedge clk_mst) begin
    word_t w;
    bit    do_pop;
    bit    do_commit;
    if (rst) begin
      m_q.delete();
      m_pend.delete();
      m_ovf  = 1'b0;
      chk_en = 1'b1;
    end else if (chk_en) begin
      do_pop    = (m_q.size() > 0) && ready_i;
      do_commit = 1'b0;
      if (valid_i) m_pend.push_back(data_i);
      if (m_pend.size() == 4 || (flush_i && m_pend.size() > 0)) begin
        w.data = '0;
        w.be   = '0;
        for (int unsigned i = 0; i < m_pend.size(); i++) begin
          w.data = w.data | (32'(m_pend[i]) << (8 * i));
          w.be[i] = 1'b1;
        end
        do_commit = 1'b1;
        m_pend.delete();
      end
      if (do_pop) void'(m_q.pop_front());
      if (do_commit) begin
        if (m_q.size() < DEPTH) m_q.push_back(w);
        else m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk_mst) begin
    if (chk_en) begin
      chk("valid_o",  32'(valid_o),  32'(m_q.size() != 0));
      chk("level_o",  32'(level_o),  32'(m_q.size()));
      chk("full",     32'(full),     32'(m_q.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (m_q.size() != 0) begin
        chk("data_o",    data_o,          m_q[0].data);
        chk("byte_en_o", 32'(byte_en_o),  32'(m_q[0].be));
      end
    end
  end

  task automatic cyc(input logic r, input logic v, input logic [7:0] d,
                     input logic f, input logic rdy);
    rst     = r;
    valid_i = v;
    data_i  = d;
    flush_i = f;
    ready_i = rdy;
    @(posedge clk_mst);
    #1;
  endtask

  initial begin
    // reset
    cyc(1, 0, 8'h00, 0, 0);
    chk("rst valid_o",   32'(valid_o),   32'd0);
    chk("rst level_o",   32'(level_o),   32'd0);
    chk("rst full",      32'(full),      32'd0);
    chk("rst overflow",  32'(overflow),  32'd0);
    chk("rst data_o",    data_o,         32'h0);
    chk("rst byte_en_o", 32'(byte_en_o), 32'h0);

    // full-word pack, popped the following cycle
    cyc(0, 1, 8'h11, 0, 1);
    cyc(0, 1, 8'h22, 0, 1);
    cyc(0, 1, 8'h33, 0, 1);
    chk("pack early valid_o", 32'(valid_o), 32'd0);
    cyc(0, 1, 8'h44, 0, 1);
    chk("pack valid_o", 32'(valid_o),   32'd1);
    chk("pack data_o",  data_o,         32'h44332211);
    chk("pack be",      32'(byte_en_o), 32'hF);
    cyc(0, 0, 8'h00, 0, 1);
    chk("pack drained", 32'(level_o),   32'd0);

    // partial flush, then flush with nothing assembled
    cyc(0, 1, 8'hAA, 0, 0);
    cyc(0, 1, 8'hBB, 0, 0);
    cyc(0, 0, 8'h00, 1, 0);
    chk("flush data_o", data_o,         32'h0000BBAA);
    chk("flush be",     32'(byte_en_o), 32'h3);
    cyc(0, 0, 8'h00, 1, 0);
    chk("empty flush level", 32'(level_o), 32'd1);
    cyc(0, 0, 8'h00, 0, 1);

    // valid and flush together on the 4th byte
    cyc(0, 1, 8'h01, 0, 0);
    cyc(0, 1, 8'h02, 0, 0);
    cyc(0, 1, 8'h03, 0, 0);
    cyc(0, 1, 8'h04, 1, 0);
    chk("vf level",  32'(level_o),   32'd1);
    chk("vf data_o", data_o,         32'h04030201);
    chk("vf be",     32'(byte_en_o), 32'hF);
    cyc(0, 0, 8'h00, 0, 1);

    // backpressure and overflow
    for (int unsigned i = 0; i < 20; i++) begin
      cyc(0, 1, 8'(8'h80 + i), 0, 0);
      if (i == 15) begin
        chk("bp level at 16", 32'(level_o),  32'd4);
        chk("bp full at 16",  32'(full),     32'd1);
        chk("bp ovf at 16",   32'(overflow), 32'd0);
      end
    end
    chk("bp overflow", 32'(overflow), 32'd1);
    chk("bp head",     data_o,        32'h83828180);
    for (int unsigned i = 0; i < 3; i++) cyc(0, 0, 8'h00, 0, 1);
    chk("bp last head", data_o, 32'h8F8E8D8C);
    cyc(0, 0, 8'h00, 0, 1);
    chk("bp drained",     32'(level_o),  32'd0);
    chk("bp ovf sticky",  32'(overflow), 32'd1);

    // full FIFO with pop on the committing edge
    cyc(1, 0, 8'h00, 0, 0);
    for (int unsigned i = 0; i < 19; i++) cyc(0, 1, 8'(8'hC0 + i), 0, 0);
    cyc(0, 1, 8'hD3, 0, 1);
    chk("fp level",    32'(level_o),  32'd4);
    chk("fp overflow", 32'(overflow), 32'd0);
    chk("fp head",     data_o,        32'hC7C6C5C4);
    for (int unsigned i = 0; i < 4; i++) cyc(0, 0, 8'h00, 0, 1);

    // reset mid-operation
    for (int unsigned i = 0; i < 14; i++) cyc(0, 1, 8'(8'h50 + i), 0, 0);
    cyc(1, 0, 8'h00, 0, 0);
    chk("mid rst valid_o",  32'(valid_o),  32'd0);
    chk("mid rst level_o",  32'(level_o),  32'd0);
    chk("mid rst overflow", 32'(overflow), 32'd0);
    cyc(0, 1, 8'h10, 0, 0);
    cyc(0, 1, 8'h20, 0, 0);
    cyc(0, 1, 8'h30, 0, 0);
    cyc(0, 1, 8'h40, 0, 0);
    chk("post rst data_o", data_o,         32'h40302010);
    chk("post rst be",     32'(byte_en_o), 32'hF);

    // randomised traffic with alternating consumer speed
    for (int unsigned seg = 0; seg < 8; seg++) begin
      for (int unsigned i = 0; i < 400; i++) begin
        cyc($urandom_range(0, 599) == 0,
            $urandom_range(0, 9) < 7,
            8'($urandom),
            $urandom_range(0, 9) == 0,
            (seg % 2 == 0) ? ($urandom_range(0, 9) < 1) : ($urandom_range(0, 9) < 9));
      end
    end
    cyc(0, 0, 8'h00, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/plaintext_packer.md
Name: plaintext_packer

Overview:
- Downstream stage of the decryption top level. Consumes the 8-bit decrypted byte stream (data/valid, no backpressure) produced by the output mux.
- Packs bytes little-endian into 32-bit words and buffers them in a small first-word-fall-through (FWFT) FIFO.
- Presents the words on a ready/valid master-side interface, with byte enables for partial final words.
- Flags overflow, because the decryption chain cannot be stalled at byte granularity.

Parameters:
- SYS_DWIDTH, 8, input byte width; fixed at 8, other values unsupported.
- MST_DWIDTH, 32, output word width; must equal 4*SYS_DWIDTH.
- FIFO_DEPTH, 4, number of word entries; power of two, 2 or greater.

Ports:
- clk_mst  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- data_i  input  SYS_DWIDTH  decrypted byte.
- valid_i  input  1  byte qualifier; one byte per cycle when high.
- flush_i  input  1  one-cycle pulse; commits any partial word.
- data_o  output  MST_DWIDTH  FIFO head word; byte 0 in bits [7:0].
- byte_en_o  output  4  valid lanes of data_o; bit k covers bits [8k+7:8k].
- valid_o  output  1  FIFO non-empty.
- ready_i  input  1  consumer accepts head when valid_o & ready_i.
- level_o  output  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- full  output  1  level_o == FIFO_DEPTH; meant for upstream busy throttling.
- overflow  output  1  sticky; a committed word was dropped.

Behaviour:
- Reset: one clk_mst edge with rst=1 clears the following. All outputs 0. Lane counter 0. Assembly register 0. FIFO empty. Overflow cleared. Any partial word and all buffered words are discarded, whatever was in progress.
- Assembly: while valid_i=1, data_i is written into lane cnt of the assembly register and cnt increments (mod 4). The per-lane filled mask updates with it.
- Commit conditions:
  - (a) valid_i=1 and cnt=3: a full word is committed with byte_en 4'b1111.
  - (b) flush_i=1 and filled mask non-zero: a partial word is committed. Unfilled lanes read 0. byte_en equals the filled mask.
- valid_i and flush_i in the same cycle: the byte is included first, then one commit. If cnt=3, that is a single full-word commit; never two.
- flush_i with an empty assembly register is a no-op.
- After any commit, cnt and the mask return to 0 and the assembly register is zeroed.
- Latency: the word is pushed on the committing edge. If the FIFO was empty, valid_o rises in the following cycle, one cycle after the 4th byte's edge. data_o and byte_en_o are valid whenever valid_o=1.
- FIFO: FWFT, head registered. Pop occurs on an edge where valid_o & ready_i.
  - Simultaneous push and pop is allowed at any level, including full: level unchanged and the push succeeds.
  - Pop when empty is ignored; ready_i is don't-care.
- Overflow: commit when level=FIFO_DEPTH and no pop on the same edge:
  - word dropped, FIFO unchanged;
  - overflow set and held until rst;
  - cnt and mask still cleared;
  - subsequent bytes assemble normally.
- Pointer wrap: read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Occupancy is tracked by a separate counter, so full and empty are unambiguous.
- valid_o, full and level_o are derived from registered state only; there is no combinational path from valid_i or ready_i.

Decomposition:
- Shared package plaintext_packer_pkg:
  - SYS_DWIDTH and MST_DWIDTH constants;
  - LANES = MST_DWIDTH/SYS_DWIDTH;
  - byte-enable type (LANES bits);
  - FIFO entry type {byte_en, data}.
- Sub-module sync_fifo_fwft: parameterised width and depth; ports push, pop, din, dout, level, full, empty. It contains all of the storage and pointer logic. The top contains the lane assembler, commit logic and overflow flag.

Test Plan:
- Full-word pack: after reset, valid_i on 4 consecutive cycles with bytes 0x11, 0x22, 0x33, 0x44, ready_i=1 → next cycle valid_o=1, data_o=0x44332211, byte_en_o=4'hF. Popped the same cycle, level_o returns to 0.
- Partial flush: bytes 0xAA, 0xBB, then flush_i alone → data_o=0x0000BBAA, byte_en_o=4'b0011. A further flush_i with nothing assembled pushes nothing.
- Simultaneous valid and flush: bytes 0x01, 0x02, 0x03, then 0x04 with flush_i=1 → exactly one word, 0x04030201 with byte_en 4'hF, and level_o=1.
- Backpressure and overflow: ready_i=0, stream 20 bytes → level_o reaches 4 and full=1 after 16 bytes. The 5th word is dropped and overflow=1. Then ready_i=1 → the 4 stored words drain in order and overflow stays 1.
- Full with concurrent pop: with the FIFO full, ready_i=1 exactly on the 4th-byte edge → no drop, overflow stays 0, level_o stays 4, and word order is preserved.
- Reset mid-operation: 2 bytes assembled and 3 words buffered, then rst=1 for one cycle → valid_o=0, level_o=0, overflow=0. The next 4 bytes 0x10, 0x20, 0x30, 0x40 yield 0x40302010 with no stale lanes.
